mac_seq_ctrl: RTL
=================

Name: mac_seq_ctrl

Overview:
- Sequencer for one 8x8 signed MAC accumulator cell (16-bit saturating accumulator, bias load, enable-gated register).
- Accepts a job command (bias, length), loads the bias, and streams LEN operand pairs into the MAC through a valid/ready handshake.
- Presents the final 16-bit accumulation on a valid/ready result port.
- Sits between the NPU operand fetch/streaming logic and the MAC cell. The MAC cell itself is instantiated alongside it at the PE level.

Parameters:
- CNT_W, 8, width of LEN and the internal pair counter (max job length 2^CNT_W-1).

Ports:
- CLKEXT  in  1  clock; all state updates on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  job request; sampled only in IDLE.
- LEN  in  CNT_W  number of operand pairs for the job; sampled with START.
- BIAS  in  8  unsigned bias for the job; sampled with START.
- ABORT  in  1  synchronous job cancel.
- OP_VALID  in  1  operand pair valid.
- OP_READY  out  1  controller accepts the pair this cycle.
- OP_A  in  8  signed operand A.
- OP_B  in  8  signed operand B.
- MAC_EN  out  1  drives the MAC enable.
- MAC_RST  out  1  drives the MAC bias-load select.
- MAC_BIAS  out  8  drives the MAC bias input.
- MAC_A  out  8  drives MAC operand A.
- MAC_B  out  8  drives MAC operand B.
- MAC_Y  in  16  MAC accumulator output (registered inside the MAC).
- RES_VALID  out  1  result valid.
- RES_READY  in  1  result consumer ready.
- RES_DATA  out  16  signed job result.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RSTN=0, async): state=IDLE, count=0, bias_q=0. All outputs 0: OP_READY, MAC_EN, MAC_RST, MAC_BIAS, RES_VALID, BUSY. MAC_A, MAC_B and RES_DATA follow the rules below with state=IDLE.
- States: IDLE, LOAD, ACC, DONE.
- IDLE:
  - START=1 captures LEN into count and BIAS into bias_q, then -> LOAD.
  - START in any other state is ignored.
- LOAD (exactly 1 cycle):
  - MAC_EN=1, MAC_RST=1, MAC_BIAS=bias_q. The MAC holds zero-extended bias after this edge.
  - count==0 -> DONE; otherwise -> ACC.
- ACC:
  - OP_READY=1.
  - MAC_A=OP_A and MAC_B=OP_B combinationally.
  - MAC_EN = OP_VALID & OP_READY, MAC_RST=0.
  - Each accepted pair decrements count. Accepting the pair when count==1 -> DONE.
  - OP_VALID low stalls with no MAC update. There is no timeout.
- DONE:
  - RES_VALID=1, RES_DATA=MAC_Y, MAC_EN=0 (accumulator frozen).
  - RES_VALID & RES_READY -> IDLE.
  - RES_DATA must be stable while RES_VALID=1 and RES_READY=0.
- Latency: START edge -> LOAD -> first pair accept earliest in the 2nd cycle after START. RES_VALID is asserted in the cycle after the last pair accept (MAC_Y already updated at that edge). LEN=0 gives RES_VALID 2 cycles after START.
- Throughput: 1 pair/cycle in ACC.
- Outside ACC: OP_READY=0, MAC_A=MAC_B=0.
- Outside LOAD: MAC_RST=0, MAC_BIAS=0.
- Outside DONE: RES_DATA=0.
- ABORT=1 in LOAD/ACC/DONE -> IDLE next edge. MAC_EN is forced 0 that cycle, no result is produced, and the MAC content is left stale.
  - ABORT beats a simultaneous pair accept (the pair is not consumed; OP_READY=0 when ABORT=1).
  - ABORT in IDLE beats START.
- Saturation is performed by the MAC. The controller does no arithmetic besides the count decrement (never wraps; guarded by count!=0).
- Async reset mid-job: immediate return to IDLE; the MAC is not cleared (next LOAD overwrites it).

Optional Feature:
- Macro: MAC_SEQ_CTRL_RELU_EN.
- Defined: RES_DATA = MAC_Y[15] ? 16'h0000 : MAC_Y in DONE (ReLU applied on the result port only).
- Undefined: RES_DATA = MAC_Y unmodified.

Decomposition:
- Shared package npu_pkg holds:
  - state encoding (IDLE=2'd0, LOAD=2'd1, ACC=2'd2, DONE=2'd3);
  - MAC operand width 8, accumulator width 16;
  - saturation constants 16'h7FFF / 16'h8000 for bench checks.
- No sub-module: a single FSM plus counter. Bench and PE top instantiate mac_seq_ctrl with the existing MAC cell.

Test Plan:
- BIAS=5, LEN=3, pairs (2,3),(-4,5),(7,1) streamed back-to-back, RES_READY=1 -> RES_VALID 1 cycle after the 3rd accept, RES_DATA=16'hFFFE (-2); with RELU_EN -> 16'h0000.
- BIAS=200, LEN=0 -> LOAD then DONE; RES_DATA=16'h00C8 two cycles after START; OP_READY never high.
- BIAS=0, LEN=3, pairs (127,127)x3 -> RES_DATA=16'h7FFF (saturated); with (-128,127)x3 -> 16'h8000.
- LEN=4 with OP_VALID toggling 1,0,0,1,1,0,1 and RES_READY low for 5 cycles -> exactly 4 MAC_EN pulses, correct sum, RES_DATA and RES_VALID held constant until RES_READY rises.
- ABORT asserted on the 2nd accept cycle of LEN=5 -> that pair not consumed, IDLE next cycle, no RES_VALID; a following START with BIAS=1, LEN=1, (3,3) -> RES_DATA=16'h000A.
- RSTN pulsed low mid-ACC -> all outputs 0 immediately, BUSY=0. START while BUSY is ignored (no counter reload).

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: sequencer state encoding, MAC widths, saturation limits.
package npu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ACC  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int OP_W  = 8;
   localparam int ACC_W = 16;

   localparam logic [ACC_W-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [ACC_W-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for one signed 8x8 MAC cell: bias load, LEN operand pairs, result handshake.
// Optional MAC_SEQ_CTRL_RELU_EN clamps negative results to zero on the result port only.
module mac_seq_ctrl
   import npu_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             CLKEXT,
   input  logic             RSTN,
   input  logic             START,
   input  logic [CNT_W-1:0] LEN,
   input  logic [OP_W-1:0]  BIAS,
   input  logic             ABORT,
   input  logic             OP_VALID,
   output logic             OP_READY,
   input  logic [OP_W-1:0]  OP_A,
   input  logic [OP_W-1:0]  OP_B,
   output logic             MAC_EN,
   output logic             MAC_RST,
   output logic [OP_W-1:0]  MAC_BIAS,
   output logic [OP_W-1:0]  MAC_A,
   output logic [OP_W-1:0]  MAC_B,
   input  logic [ACC_W-1:0] MAC_Y,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic [ACC_W-1:0] RES_DATA,
   output logic             BUSY
);

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [OP_W-1:0]  bias_q,  bias_d;
   logic             accept;

   always_ff @(posedge CLKEXT or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         bias_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         bias_q  <= bias_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      bias_d    = bias_q;
      OP_READY  = 1'b0;
      MAC_EN    = 1'b0;
      MAC_RST   = 1'b0;
      MAC_BIAS  = '0;
      MAC_A     = '0;
      MAC_B     = '0;
      RES_VALID = 1'b0;
      RES_DATA  = '0;
      accept    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (START && !ABORT) begin
               count_d = LEN;
               bias_d  = BIAS;
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            MAC_EN   = !ABORT;
            MAC_RST  = 1'b1;
            MAC_BIAS = bias_q;
            if (ABORT)
               state_d = ST_IDLE;
            else if (count_q == '0)
               state_d = ST_DONE;
            else
               state_d = ST_ACC;
         end

         ST_ACC: begin
            // Abort withdraws ready so a concurrent pair is never consumed.
            OP_READY = !ABORT;
            MAC_A    = OP_A;
            MAC_B    = OP_B;
            accept   = OP_VALID && !ABORT && (count_q != '0);
            MAC_EN   = accept;
            if (ABORT) begin
               state_d = ST_IDLE;
            end else if (accept) begin
               count_d = count_q - CNT_ONE;
               if (count_q == CNT_ONE)
                  state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            RES_VALID = !ABORT;
`ifdef MAC_SEQ_CTRL_RELU_EN
            RES_DATA  = MAC_Y[ACC_W-1] ? '0 : MAC_Y;
`else
            RES_DATA  = MAC_Y;
`endif
            if (ABORT || RES_READY)
               state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign BUSY = (state_q != ST_IDLE);

endmodule
